// File: rtl/wb_data_sel_seq.sv
// wb_data_sel_seq: sequential write-back data selector for the multicycle core.
// Picks ALU / load / compare flag / PC+4 / immediate, extracts and extends
// sub-word loads, waits a bounded time for memory and issues a one-cycle
// register-file write strobe.
// Optional feature macro: MISALIGN_CHK_EN (adds the misalign output and
// rejects loads whose byte offset is not a multiple of the access size).
module wb_data_sel_seq #(
    parameter int XLEN        = 64,
    parameter int SEL_W       = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SEL_W-1:0] select,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             mem_valid,
    input  logic [1:0]       load_size,
    input  logic             load_unsigned,
    input  logic [2:0]       byte_ofs,
    input  logic             lt_flag,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_valid,
    output logic             busy,
    output logic             timeout
`ifdef MISALIGN_CHK_EN
    ,
    output logic             misalign
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WB       = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       size_r, size_s;
    logic             uns_r, uns_s;
    logic [2:0]       ofs_r, ofs_s;
    logic [XLEN-1:0]  wb_data_r, wb_data_s;
    logic             wb_valid_r, wb_valid_s;
    logic             busy_r, busy_s;
    logic             timeout_r, timeout_s;
`ifdef MISALIGN_CHK_EN
    logic             misalign_r, misalign_s;
`endif

    // Non-load result: compare flag is zero-extended, unused codes give zero.
    function automatic logic [XLEN-1:0] direct_result(
        input logic [SEL_W-1:0] sel,
        input logic [XLEN-1:0]  alu,
        input logic             lt,
        input logic [XLEN-1:0]  pc4,
        input logic [XLEN-1:0]  immv
    );
        logic [XLEN-1:0] res;
        case (sel)
            SEL_W'(0): res = alu;
            SEL_W'(2): res = {{(XLEN-1){1'b0}}, lt};
            SEL_W'(3): res = pc4;
            SEL_W'(4): res = immv;
            default:   res = '0;
        endcase
        return res;
    endfunction

    // Shift the addressed lane down (zeros enter from the top), truncate to
    // the access size, then sign- or zero-extend. On XLEN=32 a double access
    // degrades to a word and the top offset bit is dropped.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0] data,
        input logic [1:0]      size,
        input logic            uns,
        input logic [2:0]      ofs
    );
        logic [2:0]      eff_ofs;
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] mask;
        logic            sign;
        eff_ofs = (XLEN == 32) ? {1'b0, ofs[1:0]} : ofs;
        lane    = data >> {eff_ofs, 3'b000};
        case (size)
            2'd0:    mask = ~({XLEN{1'b1}} << 7'd8);
            2'd1:    mask = ~({XLEN{1'b1}} << 7'd16);
            2'd2:    mask = ~({XLEN{1'b1}} << 7'd32);
            default: mask = (XLEN == 32) ? ~({XLEN{1'b1}} << 7'd32) : {XLEN{1'b1}};
        endcase
        // Sign bit is the top bit of the mask; for full-width accesses the
        // upper fill is empty so sign vs. zero extension makes no difference.
        sign = |(lane & mask & ~(mask >> 1));
        if (!uns && sign) begin
            return lane | ~mask;
        end else begin
            return lane & mask;
        end
    endfunction

`ifdef MISALIGN_CHK_EN
    // Offset must be a multiple of the access size (word size caps at 4 on XLEN=32).
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [2:0] ofs
    );
        logic res;
        case (size)
            2'd0:    res = 1'b0;
            2'd1:    res = ofs[0];
            2'd2:    res = |ofs[1:0];
            2'd3:    res = (XLEN == 32) ? |ofs[1:0] : |ofs;
            default: res = 1'b0;
        endcase
        return res;
    endfunction
`endif

    // Next-state and next-output logic for the write-back sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        size_s     = size_r;
        uns_s      = uns_r;
        ofs_s      = ofs_r;
        wb_data_s  = wb_data_r;
        wb_valid_s = 1'b0;
        timeout_s  = 1'b0;
`ifdef MISALIGN_CHK_EN
        misalign_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    size_s = load_size;
                    uns_s  = load_unsigned;
                    ofs_s  = byte_ofs;
                    if (select != SEL_LOAD) begin
                        wb_data_s  = direct_result(select, alu_out, lt_flag, pc_plus4, imm);
                        wb_valid_s = 1'b1;
                        state_s    = ST_WB;
                    end
`ifdef MISALIGN_CHK_EN
                    else if (is_misaligned(load_size, byte_ofs)) begin
                        misalign_s = 1'b1;
                        state_s    = ST_IDLE;
                    end
`endif
                    else if (mem_valid) begin
                        wb_data_s  = extract_load(mem_data, load_size, load_unsigned, byte_ofs);
                        wb_valid_s = 1'b1;
                        state_s    = ST_WB;
                    end else begin
                        cnt_s   = '0;
                        state_s = ST_WAIT_MEM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_valid) begin
                    wb_data_s  = extract_load(mem_data, size_r, uns_r, ofs_r);
                    wb_valid_s = 1'b1;
                    state_s    = ST_WB;
                end else if (cnt_r == CNT_LAST) begin
                    // Abort: clear the result and skip the register write.
                    wb_data_s = '0;
                    timeout_s = 1'b1;
                    state_s   = ST_WB;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WB: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, latched load attributes and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            ofs_r      <= 3'd0;
            wb_data_r  <= '0;
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
`ifdef MISALIGN_CHK_EN
            misalign_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            size_r     <= size_s;
            uns_r      <= uns_s;
            ofs_r      <= ofs_s;
            wb_data_r  <= wb_data_s;
            wb_valid_r <= wb_valid_s;
            busy_r     <= busy_s;
            timeout_r  <= timeout_s;
`ifdef MISALIGN_CHK_EN
            misalign_r <= misalign_s;
`endif
        end
    end

    assign wb_data  = wb_data_r;
    assign wb_valid = wb_valid_r;
    assign busy     = busy_r;
    assign timeout  = timeout_r;
`ifdef MISALIGN_CHK_EN
    assign misalign = misalign_r;
`endif

endmodule
